// File: rtl/csa_resolver.sv
// Carry-save frame accumulator: absorbs redundant (sum, carry) beats without
// carry propagation, then resolves the total CHUNK bits per cycle.
module csa_resolver #(
  parameter int W     = 24,
  parameter int IN_W  = 16,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_sum,
  input  logic [IN_W-1:0] in_carry,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            busy
);

  // state   | meaning
  // ACCUM   | accepting beats into the carry-save pair
  // RESOLVE | rippling acc_s + acc_c one chunk per cycle
  // OUTPUT  | holding the resolved total until out_ready
  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  localparam int NCH = W / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t          state, state_nxt;
  logic [W-1:0]    acc_s, acc_c;
  logic [KW-1:0]   k;
  logic            cin;
  logic            accept;
  logic [W-1:0]    op_a, op_b;
  logic [W-1:0]    l1_s, l1_c, l2_s, l2_c;
  logic [CHUNK:0]  csum;

  assign accept = in_valid && in_ready;

  // Two 3:2 levels reduce {acc_s, acc_c, sum, carry<<1} to a new pair.
  assign op_a = W'(in_sum);
  assign op_b = W'({in_carry, 1'b0});
  assign l1_s = acc_s ^ acc_c ^ op_a;
  assign l1_c = W'({(acc_s & acc_c) | (acc_s & op_a) | (acc_c & op_a), 1'b0});
  assign l2_s = l1_s ^ l1_c ^ op_b;
  assign l2_c = W'({(l1_s & l1_c) | (l1_s & op_b) | (l1_c & op_b), 1'b0});

  assign csum = {1'b0, acc_s[k*CHUNK +: CHUNK]} + {1'b0, acc_c[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = RESOLVE;
      RESOLVE: if (k == KW'(NCH - 1)) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == OUTPUT);
    busy      = (state != ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_s    <= '0;
      acc_c    <= '0;
      k        <= '0;
      cin      <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_s <= l2_s;
            acc_c <= l2_c;
            if (in_last) begin
              k   <= '0;
              cin <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          // Carry out of the top chunk is dropped: result wraps mod 2^W.
          out_data[k*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
          cin <= csum[CHUNK];
          k   <= k + 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            acc_s <= '0;
            acc_c <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed and randomized frames checked
// against an arithmetic frame-total model.
module tb_csa_resolver;

  localparam int W = 24;
  localparam int IN_W = 16;
  localparam int NCH = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_sum;
  logic [IN_W-1:0] in_carry;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            busy;

  int errors = 0;
  int checks = 0;

  csa_resolver dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: value of one beat, plain integer arithmetic mod 2^W.
  function automatic logic [W-1:0] beat_val(logic [IN_W-1:0] s, logic [IN_W-1:0] c);
    longint v;
    v = longint'(s) + 2 * longint'(c);
    return v[W-1:0];
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_beat(logic [IN_W-1:0] s, logic [IN_W-1:0] c, logic last);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h busy=%b ready=%b, need 0 000000 0 1",
               out_valid, out_data, busy, in_ready);
    end
  endtask

  task automatic test_single();
    int lat;
    send_beat(16'h0005, 16'h0003, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_resolving: got valid=%b busy=%b ready=%b, need 0 1 0",
               out_valid, busy, in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== NCH) begin
      errors++;
      $display("FAIL single_latency: got %0d edges, need %0d", lat, NCH);
    end
    checks++;
    if (out_data !== 24'h00000B || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_data: got %h ready=%b, need 00000b ready=0", out_data, in_ready);
    end
    take_output();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got valid=%b ready=%b busy=%b, need 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_multi(int nbeats, logic [W-1:0] want, string name);
    int lat;
    logic [W-1:0] model;
    model = '0;
    for (int b = 0; b < nbeats; b++) begin
      model = model + beat_val(16'hFFFF, 16'hFFFF);
      send_beat(16'hFFFF, 16'hFFFF, b == nbeats - 1);
    end
    wait_valid(lat);
    checks++;
    if (lat !== NCH || out_data !== want || out_data !== model) begin
      errors++;
      $display("FAIL %s: got lat=%0d data=%h, need lat=%0d data=%h (model %h)",
               name, lat, out_data, NCH, want, model);
    end
    take_output();
  endtask

  task automatic test_random();
    int lat, len;
    logic [IN_W-1:0] s, c;
    logic [W-1:0] model;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 10);
      model = '0;
      for (int b = 0; b < len; b++) begin
        s = IN_W'($urandom);
        c = IN_W'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          s = '0;
          c = '0;
        end
        model = model + beat_val(s, c);
        send_beat(s, c, b == len - 1);
      end
      wait_valid(lat);
      checks++;
      if (lat !== NCH || out_data !== model) begin
        errors++;
        $display("FAIL random_frame%0d: got lat=%0d data=%h, need lat=%0d data=%h",
                 f, lat, out_data, NCH, model);
      end
      take_output();
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [IN_W-1:0] s, c;
    logic [W-1:0] model;
    model = '0;
    for (int b = 0; b < 3; b++) begin
      s = IN_W'($urandom);
      c = IN_W'($urandom);
      model = model + beat_val(s, c);
      send_beat(s, c, b == 2);
    end
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sum   = IN_W'($urandom);
      in_carry = IN_W'($urandom);
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== model || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b data=%h ready=%b, need 1 %h 0",
                 i, out_valid, out_data, in_ready, model);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_output();
    send_beat(16'h0007, 16'h0000, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== NCH || out_data !== 24'h000007) begin
      errors++;
      $display("FAIL stall_next_frame: got lat=%0d data=%h, need lat=%0d data=000007",
               lat, out_data, NCH);
    end
    take_output();
  endtask

  task automatic test_reset_mid();
    int lat;
    send_beat(16'h1234, 16'h0042, 1'b0);
    send_beat(16'hABCD, 16'h0101, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: got valid=%b busy=%b ready=%b data=%h, need 0 0 1 000000",
               out_valid, busy, in_ready, out_data);
    end
    send_beat(16'h0001, 16'h0000, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== NCH || out_data !== 24'h000001) begin
      errors++;
      $display("FAIL reset_mid_next: got lat=%0d data=%h, need lat=%0d data=000001",
               lat, out_data, NCH);
    end
    take_output();
  endtask

  task automatic test_back_to_back();
    localparam int NF = 6;
    int len[NF];
    logic [IN_W-1:0] fs[NF][8];
    logic [IN_W-1:0] fc[NF][8];
    logic [W-1:0] tot[NF];
    int fi, bi, oi, gap, cyc;
    for (int f = 0; f < NF; f++) begin
      len[f] = $urandom_range(1, 8);
      tot[f] = '0;
      for (int b = 0; b < len[f]; b++) begin
        fs[f][b] = IN_W'($urandom);
        fc[f][b] = IN_W'($urandom);
        tot[f] = tot[f] + beat_val(fs[f][b], fc[f][b]);
      end
    end
    fi = 0; bi = 0; oi = 0; gap = -1; cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (oi < NF && cyc < 3000) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== tot[oi]) begin
          errors++;
          $display("FAIL b2b_frame%0d: got %h, need %h", oi, out_data, tot[oi]);
        end
        oi++;
      end
      if (gap >= 0) begin
        if (in_ready === 1'b1) begin
          checks++;
          if (gap != NCH + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d stalled cycles, need %0d", gap, NCH + 1);
          end
          gap = -1;
        end else begin
          gap++;
        end
      end
      if (in_ready === 1'b1 && fi < NF) begin
        in_sum   = fs[fi][bi];
        in_carry = fc[fi][bi];
        in_last  = (bi == len[fi] - 1);
        if (bi == len[fi] - 1) begin
          fi++;
          bi = 0;
          gap = 0;
        end else begin
          bi++;
        end
      end else begin
        in_sum   = IN_W'($urandom);
        in_carry = IN_W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    checks++;
    if (oi != NF) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d frames, need %0d", oi, NF);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_multi(4, 24'h0BFFF4, "four_beats");
    test_multi(256, 24'hFFFD00, "wrap_256");
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
